// File: rtl/mag15_arbiter_if.sv
// Request/response bundle for mag15_arbiter.
// master: requesters + result consumer; slave: the arbiter.
interface mag15_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]      req_valid;
    logic [15*NREQ-1:0]   req_a;
    logic [15*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic                 rsp_gt;
    logic                 rsp_eq;
    logic                 rsp_lt;

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_gt,
        input  rsp_eq,
        input  rsp_lt
    );

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_id,
        output rsp_gt,
        output rsp_eq,
        output rsp_lt
    );
endinterface

// File: rtl/mag15_arbiter.sv
// Round-robin share of one 15-bit magnitude comparator among NREQ clients.
// Ports: clk, rst_n (async low), bus (slave: req/rsp handshakes), cmp_count.
module mag15_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    mag15_arbiter_if.slave  bus,
    output logic [CNTW-1:0] cmp_count
);
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win;
    logic [IDW-1:0] ptr_nxt;
    logic           any;
    logic           accept;
    logic           s1_free;
    logic           s2_load;

    logic           s1_valid;
    logic [14:0]    s1_a;
    logic [14:0]    s1_b;
    logic [IDW-1:0] s1_id;

    logic           cmp_gt;
    logic           cmp_eq;
    logic           cmp_lt;

    logic           s2_valid;
    logic [IDW-1:0] s2_id;
    logic           s2_gt;
    logic           s2_eq;
    logic           s2_lt;

    logic [14:0]    win_a;
    logic [14:0]    win_b;

    // Scan NREQ slots starting at the pointer; first valid one wins.
    always_comb begin
        logic [IDW:0]   sum;
        logic [IDW-1:0] cand;
        any = 1'b0;
        win = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ))
                sum = sum - (IDW+1)'(NREQ);
            cand = sum[IDW-1:0];
            if (!any && bus.req_valid[cand]) begin
                any = 1'b1;
                win = cand;
            end
        end
    end

    always_comb begin
        logic [IDW:0] inc;
        inc = {1'b0, win} + {{IDW{1'b0}}, 1'b1};
        if (inc >= (IDW+1)'(NREQ))
            ptr_nxt = '0;
        else
            ptr_nxt = inc[IDW-1:0];
    end

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                win_a = bus.req_a[15*i +: 15];
                win_b = bus.req_b[15*i +: 15];
            end
        end
    end

    assign s2_load = s1_valid && (!s2_valid || bus.rsp_ready);
    assign s1_free = !s1_valid || s2_load;
    assign accept  = s1_free && any;

    // Gated with rst_n so no client sees a grant while held in reset.
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && accept)
            bus.req_ready = NREQ'(1) << win;
    end

    // The single shared comparator, fed straight from the operand register.
    assign cmp_gt = s1_a > s1_b;
    assign cmp_eq = s1_a == s1_b;
    assign cmp_lt = s1_a < s1_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_a     <= win_a;
                s1_b     <= win_b;
                s1_id    <= win;
                ptr      <= ptr_nxt;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Result register only changes on a load, so it stays put under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_id    <= '0;
            s2_gt    <= 1'b0;
            s2_eq    <= 1'b0;
            s2_lt    <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_valid <= 1'b1;
                s2_id    <= s1_id;
                s2_gt    <= cmp_gt;
                s2_eq    <= cmp_eq;
                s2_lt    <= cmp_lt;
            end else if (bus.rsp_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cmp_count <= '0;
        else if (accept && cmp_count != {CNTW{1'b1}})
            cmp_count <= cmp_count + 1'b1;
    end

    assign bus.rsp_valid = s2_valid;
    assign bus.rsp_id    = s2_id;
    assign bus.rsp_gt    = s2_gt;
    assign bus.rsp_eq    = s2_eq;
    assign bus.rsp_lt    = s2_lt;
endmodule

// File: tb/tb_mag15_arbiter.sv
// Self-checking bench for mag15_arbiter.
// Directed steps plus random traffic against a queue-based reference model.
module tb_mag15_arbiter;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 8;

    typedef struct {
        logic [IDW-1:0] id;
        logic [14:0]    a;
        logic [14:0]    b;
        int             age;
    } item_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [CNTW-1:0] cmp_count;

    mag15_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    mag15_arbiter #(
        .NREQ(NREQ),
        .IDW (IDW),
        .CNTW(CNTW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .cmp_count(cmp_count)
    );

    always #5 clk = ~clk;

    item_t       q[$];
    logic [14:0] op_a[NREQ];
    logic [14:0] op_b[NREQ];
    int          m_ptr;
    int          m_cnt;
    int          n_chk;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check against model before the edge, advance model.
    task automatic step(input logic [NREQ-1:0] v, input logic rdy);
        int             n;
        bit             mv;
        bit             free;
        bit             any;
        int             win;
        int             c;
        logic [NREQ-1:0] er;
        item_t          it;
        bus.req_valid = v;
        bus.rsp_ready = rdy;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[15*i +: 15] = op_a[i];
            bus.req_b[15*i +: 15] = op_b[i];
        end
        #4;
        n    = q.size();
        mv   = (n > 0) && (q[0].age >= 1);
        free = (n < 2) || rdy;
        any  = 1'b0;
        win  = 0;
        for (int k = 0; k < NREQ; k++) begin
            c = (m_ptr + k) % NREQ;
            if (!any && v[c]) begin
                any = 1'b1;
                win = c;
            end
        end
        er = (any && free) ? (NREQ'(1) << win) : '0;
        chk("req_ready", 32'(bus.req_ready), 32'(er));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(mv));
        if (mv) begin
            chk("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
            chk("rsp_gt", 32'(bus.rsp_gt), 32'(q[0].a > q[0].b));
            chk("rsp_eq", 32'(bus.rsp_eq), 32'(q[0].a == q[0].b));
            chk("rsp_lt", 32'(bus.rsp_lt), 32'(q[0].a < q[0].b));
        end
        chk("cmp_count", 32'(cmp_count), 32'(m_cnt));
        @(posedge clk);
        if (mv && rdy)
            void'(q.pop_front());
        foreach (q[i])
            q[i].age++;
        if (any && free) begin
            it.id  = IDW'(win);
            it.a   = op_a[win];
            it.b   = op_b[win];
            it.age = 0;
            q.push_back(it);
            m_ptr = (win + 1) % NREQ;
            if (m_cnt < (2**CNTW) - 1)
                m_cnt++;
        end
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        m_ptr  = 0;
        m_cnt  = 0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        bus.req_a     = '0;
        bus.req_b     = '0;

        #3;
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
        chk("rst_flags", 32'({bus.rsp_gt, bus.rsp_eq, bus.rsp_lt}), 32'h0);
        chk("rst_count", 32'(cmp_count), 32'h0);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        rst_n = 1'b1;

        // Single request from requester 0.
        op_a[0] = 15'h1234;
        op_b[0] = 15'h1233;
        step(4'b0001, 1'b1);
        step(4'b0000, 1'b1);
        chk("t1_valid", 32'(bus.rsp_valid), 32'h1);
        chk("t1_id", 32'(bus.rsp_id), 32'h0);
        chk("t1_flags", 32'({bus.rsp_gt, bus.rsp_eq, bus.rsp_lt}), 32'b100);
        chk("t1_count", 32'(cmp_count), 32'h1);
        step(4'b0000, 1'b1);

        // Boundary operands, one per cycle.
        op_a[0] = 15'h7FFF; op_b[0] = 15'h7FFF;
        step(4'b0001, 1'b1);
        op_a[0] = 15'h0000; op_b[0] = 15'h7FFF;
        step(4'b0001, 1'b1);
        op_a[0] = 15'h4000; op_b[0] = 15'h3FFF;
        step(4'b0001, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        // All requesters valid, full throughput.
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = 15'(100 * i + 7);
            op_b[i] = 15'(50 * i + 300);
        end
        for (int s = 0; s < 10; s++)
            step(4'b1111, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        // Backpressure: consumer stalled for 5 cycles, then drain.
        for (int s = 0; s < 5; s++)
            step(4'b1111, 1'b0);
        for (int s = 0; s < 4; s++)
            step(4'b0000, 1'b1);

        // Fairness with pointer moved to 2.
        step(4'b0010, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b1010, 1'b1);
        step(4'b1010, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b1111, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        // Asynchronous reset with both stages full.
        for (int s = 0; s < 3; s++)
            step(4'b1111, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("mrst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("mrst_count", 32'(cmp_count), 32'h0);
        q.delete();
        m_ptr = 0;
        m_cnt = 0;
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++)
            step(4'b0000, 1'b1);

        // Random traffic.
        for (int s = 0; s < 600; s++) begin
            for (int i = 0; i < NREQ; i++) begin
                op_a[i] = 15'($urandom);
                if ($urandom_range(0, 3) == 0)
                    op_b[i] = op_a[i];
                else
                    op_b[i] = 15'($urandom);
            end
            step(NREQ'($urandom), $urandom_range(0, 3) != 0);
        end
        for (int s = 0; s < 4; s++)
            step(4'b0000, 1'b1);
        chk("cnt_sat", 32'(cmp_count), 32'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mag15_arbiter.md
Name: mag15_arbiter

Overview:
- Shares one mag15 15-bit magnitude comparator among NREQ requesters.
- A round-robin arbiter grants one request per cycle into a two-stage registered pipeline: an operand register, then the mag15, then a result register.
- The result is returned on a shared response channel tagged with the requester ID, with valid/ready backpressure.
- Sits between client blocks needing occasional compares and the single comparator instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, response ID width; must equal max(1, clog2(NREQ)).
- CNTW, 16, width of the saturating accepted-compare counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req_valid  input  NREQ  per-requester request valid.
- req_a  input  15*NREQ  operand A; requester i uses bits [15*i +: 15].
- req_b  input  15*NREQ  operand B, packed the same as req_a.
- req_ready  output  NREQ  one-hot (or zero) accept strobe.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  IDW  requester index of the result.
- rsp_gt  output  1  A > B (unsigned).
- rsp_eq  output  1  A == B.
- rsp_lt  output  1  A < B.
- cmp_count  output  CNTW  number of requests accepted since reset; saturates at all-ones.

Behaviour:
- Reset (rst_n low, asynchronous):
  - s1_valid, s2_valid, rsp_valid = 0.
  - rsp_id, rsp_gt, rsp_eq, rsp_lt = 0.
  - RR pointer = 0; cmp_count = 0.
  - req_ready = 0 while in reset.
- Reset mid-operation discards all in-flight requests; no response is produced for them.
- Pipeline:
  - S1 holds {a, b, id}. The mag15 computes combinationally from S1.
  - S2 captures {id, gt, eq, lt} and drives the rsp_* outputs directly from registers.
- Advance rules:
  - s2_load = s1_valid && (!s2_valid || rsp_ready).
  - s1_free = !s1_valid || s2_load.
  - Accept happens when s1_free && |req_valid.
- Arbitration:
  - Round-robin search starting at the pointer for the first index with req_valid set. That index wins.
  - req_ready[win] = s1_free; all other bits are 0.
  - req_ready is combinational from req_valid and state. Requesters must not make req_valid depend on req_ready.
  - On accept: S1 <= {req_a[win], req_b[win], win}, s1_valid <= 1, pointer <= (win+1) mod NREQ.
  - Without an accept, the pointer holds.
- s1_valid clears when s2_load && !accept.
- s2_valid:
  - Set on s2_load.
  - Cleared on rsp_ready && !s2_load.
  - S2 data is stable while rsp_valid && !rsp_ready.
- Latency: an accept at edge N gives rsp_valid high after edge N+1. This is 1 cycle of S1 plus the registered result.
- Throughput: 1 compare per cycle when rsp_ready is held high.
- Backpressure:
  - With rsp_ready low, at most 2 requests are in flight; after that, req_ready = 0.
  - No result is dropped or duplicated.
- Exactly one of rsp_gt/rsp_eq/rsp_lt is 1 whenever rsp_valid = 1.
- cmp_count increments by 1 per accept and holds at 2^CNTW-1.
- A requester that holds req_valid is served within NREQ accepts (starvation-free).

Test Plan:
- Single request, all else idle: req 0 sends A=0x1234, B=0x1233 at edge 0 → req_ready[0]=1; rsp_valid after edge 1 with id=0, gt=1, eq=0, lt=0; cmp_count=1.
- Boundary operands, one per cycle: A=B=0x7FFF → eq=1; A=0, B=0x7FFF → lt=1; A=0x4000, B=0x3FFF → gt=1 (tests the MSB).
- All 4 requesters valid continuously, rsp_ready=1 → grants in order 0,1,2,3,0,…; rsp_id follows the same order one cycle later; one response per cycle.
- rsp_ready=0 for 5 cycles while all requesters are valid → exactly 2 accepts, then req_ready=0; rsp_valid and S2 data stay stable. Releasing rsp_ready delivers both results in order, with no loss.
- Pointer fairness: only requesters 1 and 3 valid with the pointer at 2 → grant 3 then 1; pointer ends at 2.
- Assert rst_n=0 asynchronously (mid-clock) with both stages full → rsp_valid=0 immediately; after release, no stale responses appear and cmp_count=0.
